// File: rtl/branch_predict_param_if.sv
// rtl/branch_predict_param_if.sv - Fetch/Decode/Memory signal bundle for the branch predictor
interface branch_predict_param_if #(
    parameter int STAT_W = 32
);
    logic [31:0]       pcF;
    logic              branchF;
    logic              stallD;
    logic              flushD;
    logic [31:0]       pcM;
    logic              branchM;
    logic              actual_takeM;
    logic              pred_takeM;
    logic              pred_takeD;
    logic [STAT_W-1:0] branch_cnt;
    logic [STAT_W-1:0] mispred_cnt;

    modport master (
        output pcF, branchF, stallD, flushD, pcM, branchM, actual_takeM, pred_takeM,
        input  pred_takeD, branch_cnt, mispred_cnt
    );

    modport slave (
        input  pcF, branchF, stallD, flushD, pcM, branchM, actual_takeM, pred_takeM,
        output pred_takeD, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predict_param.sv
// rtl/branch_predict_param.sv - Local-history / gshare direction predictor with saturating stats
module branch_predict_param #(
    parameter int MODE      = 0,
    parameter int BHT_IDX_W = 6,
    parameter int HIST_W    = 6,
    parameter int CNT_W     = 2,
    parameter int STAT_W    = 32
) (
    input logic                   clk,
    input logic                   rst,
    branch_predict_param_if.slave bus
);
    localparam bit GSHARE = (MODE == 1);
    localparam int BHT_N  = 1 << BHT_IDX_W;
    localparam int PHT_N  = 1 << HIST_W;
    localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [HIST_W-1:0] bht_q [BHT_N];
    logic [HIST_W-1:0] ghr_q;
    logic [CNT_W-1:0]  pht_q [PHT_N];
    logic              pred_q, pred_d;
    logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [BHT_IDX_W-1:0] bht_idx_f, bht_idx_m;
    logic [HIST_W-1:0]    idx_f, idx_m, hist_src, hist_d;
    logic [CNT_W-1:0]     cnt_m, cnt_d;
    logic                 pred_f;
    logic                 unused_pc;

    assign unused_pc = ^{bus.pcF, bus.pcM};

    always_comb begin
        bht_idx_f = bus.pcF[BHT_IDX_W+1:2];
        bht_idx_m = bus.pcM[BHT_IDX_W+1:2];
        idx_f     = GSHARE ? (ghr_q ^ bus.pcF[HIST_W+1:2]) : bht_q[bht_idx_f];
        idx_m     = GSHARE ? (ghr_q ^ bus.pcM[HIST_W+1:2]) : bht_q[bht_idx_m];
        pred_f    = bus.branchF & pht_q[idx_f][CNT_W-1];

        // Update side reads pre-update state; Fetch never sees this cycle's write.
        cnt_m = pht_q[idx_m];
        cnt_d = cnt_m;
        if (bus.actual_takeM && cnt_m != CNT_MAX) begin
            cnt_d = cnt_m + 1'b1;
        end else if (!bus.actual_takeM && cnt_m != '0) begin
            cnt_d = cnt_m - 1'b1;
        end
        hist_src = GSHARE ? ghr_q : bht_q[bht_idx_m];
        hist_d   = {hist_src[HIST_W-2:0], bus.actual_takeM};

        pred_d = pred_q;
        if (bus.flushD) begin
            pred_d = 1'b0;
        end else if (!bus.stallD) begin
            pred_d = pred_f;
        end

        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bus.branchM) begin
            if (branch_cnt_q != STAT_MAX) branch_cnt_d = branch_cnt_q + 1'b1;
            if (bus.pred_takeM != bus.actual_takeM && mispred_cnt_q != STAT_MAX) begin
                mispred_cnt_d = mispred_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= '0;
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= CNT_INIT;
            ghr_q         <= '0;
            pred_q        <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pred_q        <= pred_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            if (bus.branchM) begin
                pht_q[idx_m] <= cnt_d;
                if (GSHARE) begin
                    ghr_q <= hist_d;
                end else begin
                    bht_q[bht_idx_m] <= hist_d;
                end
            end
        end
    end

    assign bus.pred_takeD  = pred_q;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predict_param.sv
// tb/tb_branch_predict_param.sv - Directed self-checking bench for branch_predict_param
module tb_branch_predict_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    branch_predict_param_if #(.STAT_W(32)) bus1 ();
    branch_predict_param_if #(.STAT_W(3))  bus2 ();

    branch_predict_param #(.MODE(0), .BHT_IDX_W(6), .HIST_W(6), .CNT_W(2), .STAT_W(32)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    branch_predict_param #(.MODE(1), .BHT_IDX_W(6), .HIST_W(4), .CNT_W(2), .STAT_W(3)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic update1(input logic [31:0] pc, input logic act, input logic pred);
        bus1.pcM          = pc;
        bus1.actual_takeM = act;
        bus1.pred_takeM   = pred;
        bus1.branchM      = 1'b1;
        tick();
        bus1.branchM      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus1.pcF = 32'h10;
        bus1.branchF = 1'b1;
        tick();
        tests++; if (bus1.pred_takeD !== 1'b0) begin fails++; $display("FAIL reset_pred got %0b want 0", bus1.pred_takeD); end
        tests++; if (bus1.branch_cnt !== 32'd0) begin fails++; $display("FAIL reset_branch_cnt got %0d want 0", bus1.branch_cnt); end
        tests++; if (bus1.mispred_cnt !== 32'd0) begin fails++; $display("FAIL reset_mispred_cnt got %0d want 0", bus1.mispred_cnt); end
    endtask

    task automatic test_local_training();
        for (int i = 0; i < 6; i++) update1(32'h10, 1'b1, 1'b0);
        tests++; if (dut1.bht_q[4] !== 6'h3F) begin fails++; $display("FAIL train_bht got %h want 3f", dut1.bht_q[4]); end
        tick();
        tests++; if (bus1.pred_takeD !== 1'b0) begin fails++; $display("FAIL train6_pred got %0b want 0", bus1.pred_takeD); end
        update1(32'h10, 1'b1, 1'b0);
        tick();
        tests++; if (bus1.pred_takeD !== 1'b1) begin fails++; $display("FAIL train7_pred got %0b want 1", bus1.pred_takeD); end
        tests++; if (bus1.branch_cnt !== 32'd7) begin fails++; $display("FAIL train_branch_cnt got %0d want 7", bus1.branch_cnt); end
        tests++; if (bus1.mispred_cnt !== 32'd7) begin fails++; $display("FAIL train_mispred_cnt got %0d want 7", bus1.mispred_cnt); end
    endtask

    task automatic test_stall_flush();
        bus1.branchF = 1'b0;
        bus1.stallD  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (bus1.pred_takeD !== 1'b1) begin fails++; $display("FAIL stall_hold[%0d] got %0b want 1", i, bus1.pred_takeD); end
        end
        bus1.flushD = 1'b1;
        tick();
        tests++; if (bus1.pred_takeD !== 1'b0) begin fails++; $display("FAIL flush_over_stall got %0b want 0", bus1.pred_takeD); end
        bus1.flushD  = 1'b0;
        bus1.stallD  = 1'b0;
        bus1.branchF = 1'b1;
        bus1.pcF     = 32'h10;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) update1(32'h10, 1'b1, 1'b1);
        tests++; if (dut1.pht_q[63] !== 2'b11) begin fails++; $display("FAIL sat_pht_high got %b want 11", dut1.pht_q[63]); end
        tests++; if (bus1.branch_cnt !== 32'd10) begin fails++; $display("FAIL sat_branch_cnt got %0d want 10", bus1.branch_cnt); end
        update1(32'h10, 1'b0, 1'b1);
        tests++; if (dut1.pht_q[63] !== 2'b10) begin fails++; $display("FAIL sat_pht_dec got %b want 10", dut1.pht_q[63]); end
        tests++; if (dut1.bht_q[4] !== 6'h3E) begin fails++; $display("FAIL sat_bht got %h want 3e", dut1.bht_q[4]); end
        tests++; if (bus1.mispred_cnt !== 32'd8) begin fails++; $display("FAIL sat_mispred_cnt got %0d want 8", bus1.mispred_cnt); end
        tests++; if (bus1.branch_cnt !== 32'd11) begin fails++; $display("FAIL sat_branch_cnt2 got %0d want 11", bus1.branch_cnt); end
        tick();
        tests++; if (bus1.pred_takeD !== 1'b0) begin fails++; $display("FAIL sat_pred_newhist got %0b want 0", bus1.pred_takeD); end
    endtask

    task automatic test_gshare();
        bus2.branchM = 1'b1; bus2.pcM = 32'h04; bus2.actual_takeM = 1'b1; bus2.pred_takeM = 1'b0;
        tick();
        bus2.pcM = 32'h08; bus2.actual_takeM = 1'b0; bus2.pred_takeM = 1'b0;
        tick();
        bus2.branchM = 1'b0;
        tests++; if (dut2.ghr_q !== 4'b0010) begin fails++; $display("FAIL gs_ghr got %b want 0010", dut2.ghr_q); end
        bus2.branchF = 1'b1; bus2.pcF = 32'h08;
        tick();
        tests++; if (bus2.pred_takeD !== 1'b0) begin fails++; $display("FAIL gs_pred_08 got %0b want 0", bus2.pred_takeD); end
        bus2.pcF = 32'h0C;
        tick();
        tests++; if (bus2.pred_takeD !== 1'b1) begin fails++; $display("FAIL gs_pred_0c got %0b want 1", bus2.pred_takeD); end
        tests++; if (bus2.branch_cnt !== 3'd2) begin fails++; $display("FAIL gs_branch_cnt got %0d want 2", bus2.branch_cnt); end
        tests++; if (bus2.mispred_cnt !== 3'd1) begin fails++; $display("FAIL gs_mispred_cnt got %0d want 1", bus2.mispred_cnt); end
        bus2.branchM = 1'b1; bus2.pcM = 32'h0; bus2.actual_takeM = 1'b1; bus2.pred_takeM = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        bus2.branchM = 1'b0;
        tests++; if (bus2.branch_cnt !== 3'd7) begin fails++; $display("FAIL gs_stat_sat_branch got %0d want 7", bus2.branch_cnt); end
        tests++; if (bus2.mispred_cnt !== 3'd7) begin fails++; $display("FAIL gs_stat_sat_mispred got %0d want 7", bus2.mispred_cnt); end
    endtask

    task automatic test_conflict();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus1.pcF = 32'h40; bus1.branchF = 1'b1;
        bus1.pcM = 32'h20; bus1.actual_takeM = 1'b1; bus1.pred_takeM = 1'b0; bus1.branchM = 1'b1;
        tick();
        bus1.branchM = 1'b0;
        tests++; if (bus1.pred_takeD !== 1'b0) begin fails++; $display("FAIL conflict_old got %0b want 0", bus1.pred_takeD); end
        tick();
        tests++; if (bus1.pred_takeD !== 1'b1) begin fails++; $display("FAIL conflict_new got %0b want 1", bus1.pred_takeD); end
    endtask

    task automatic test_reset_mid();
        update1(32'h10, 1'b1, 1'b0);
        update1(32'h10, 1'b1, 1'b0);
        bus1.branchM = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus1.branchM = 1'b0;
        tests++; if (bus1.branch_cnt !== 32'd0) begin fails++; $display("FAIL rmid_branch_cnt got %0d want 0", bus1.branch_cnt); end
        tests++; if (bus1.mispred_cnt !== 32'd0) begin fails++; $display("FAIL rmid_mispred_cnt got %0d want 0", bus1.mispred_cnt); end
        tests++; if (bus1.pred_takeD !== 1'b0) begin fails++; $display("FAIL rmid_pred got %0b want 0", bus1.pred_takeD); end
        tests++; if (dut1.bht_q[8] !== 6'h00) begin fails++; $display("FAIL rmid_bht got %h want 00", dut1.bht_q[8]); end
        tests++; if (dut1.pht_q[0] !== 2'b01) begin fails++; $display("FAIL rmid_pht got %b want 01", dut1.pht_q[0]); end
        bus1.pcF = 32'h40; bus1.branchF = 1'b1;
        tick();
        tests++; if (bus1.pred_takeD !== 1'b0) begin fails++; $display("FAIL rmid_refetch got %0b want 0", bus1.pred_takeD); end
    endtask

    initial begin
        bus1.pcF = '0; bus1.branchF = 1'b0; bus1.stallD = 1'b0; bus1.flushD = 1'b0;
        bus1.pcM = '0; bus1.branchM = 1'b0; bus1.actual_takeM = 1'b0; bus1.pred_takeM = 1'b0;
        bus2.pcF = '0; bus2.branchF = 1'b0; bus2.stallD = 1'b0; bus2.flushD = 1'b0;
        bus2.pcM = '0; bus2.branchM = 1'b0; bus2.actual_takeM = 1'b0; bus2.pred_takeM = 1'b0;
        test_reset();
        test_local_training();
        test_stall_flush();
        test_saturation();
        test_gshare();
        test_conflict();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/branch_predict_param.md
Name: branch_predict_param

Overview:
- Parametrised successor to the pipeline's single-mode local-history branch predictor.
- Predicts conditional-branch direction at Fetch and registers the prediction into Decode.
- Trains from the resolved outcome at Memory.
- Two run-time-fixed modes: local history (per-PC history table feeding a shared pattern table) or gshare (global history XOR PC).
- Counter width and table depths are configurable; saturating performance counters track branches and mispredictions.

Parameters:
- MODE, 0: 0 = local history, 1 = gshare; any other value behaves as 0.
- BHT_IDX_W, 6: log2 of local-history table entries, indexed by pc[BHT_IDX_W+1:2]; unused when MODE=1.
- HIST_W, 6: history length in bits; pattern table has 2^HIST_W entries.
- CNT_W, 2: saturating-counter width (≥2).
- STAT_W, 32: performance-counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low; takes effect on a rising clk edge while rst=0
- pcF  in  32  Fetch PC
- branchF  in  1  Fetch instruction is a conditional branch
- stallD  in  1  hold Decode-stage registers
- flushD  in  1  clear Decode-stage registers
- pcM  in  32  PC of instruction in Memory
- branchM  in  1  Memory instruction is a conditional branch (update enable)
- actual_takeM  in  1  resolved branch direction
- pred_takeM  in  1  prediction that was carried with the Memory instruction
- pred_takeD  out  1  registered prediction for the Decode instruction
- branch_cnt  out  STAT_W  branches resolved since reset
- mispred_cnt  out  STAT_W  mispredictions since reset

Behaviour:
- Reset (rst=0 at a clk edge):
  - all history registers (BHT entries, or GHR) cleared to 0;
  - all pattern counters set to weakly-not-taken, value 2^(CNT_W-1)-1 (01 for CNT_W=2);
  - pred_takeD, branch_cnt and mispred_cnt cleared to 0.
  - Reset mid-training discards all learned state.
- Index at Fetch (combinational):
  - MODE 0: h = BHT[pcF[BHT_IDX_W+1:2]]; idx = h.
  - MODE 1: idx = GHR ^ pcF[HIST_W+1:2].
  - predF = branchF & PHT[idx][CNT_W-1].
- Decode register, one-cycle latency:
  - flushD=1: pred_takeD ← 0. flushD has priority over stallD.
  - else stallD=1: pred_takeD holds.
  - else: pred_takeD ← predF.
- Update at Memory, when branchM=1:
  - Index is computed from pcM with the same formula as Fetch, using the current (pre-update) history.
  - Counter: actual_takeM=1 increments, saturating at 2^CNT_W-1; actual_takeM=0 decrements, saturating at 0.
  - History: MODE 0 sets BHT[pcM idx] ← {old[HIST_W-2:0], actual_takeM}; MODE 1 sets GHR ← {GHR[HIST_W-2:0], actual_takeM}.
  - The history table is updated non-speculatively, at Memory only.
- Simultaneous Fetch read and Memory write to the same entry: Fetch sees the pre-update value (no bypass). The new value is visible from the next cycle.
- Statistics, when branchM=1:
  - branch_cnt increments.
  - If pred_takeM≠actual_takeM, mispred_cnt increments.
  - Both counters saturate at all-ones and never wrap.
- When branchM=0, no table or counter changes. pcM and actual_takeM are ignored.
- pc[1:0] is always ignored. Aliasing between PCs that share index bits is permitted and not detected.

Test Plan:
- Reset, default params, MODE 0: rst=0 for 1 cycle, then pcF=0x10, branchF=1 → pred_takeD=0 the next cycle; branch_cnt=0, mispred_cnt=0.
- Local training: 6 updates (pcM=0x10, branchM=1, actual_takeM=1, pred_takeM=0).
  - After them: BHT[4]=0x3F, PHT[0x3F]=01 → prediction for pcF=0x10 is 0.
  - 7th update → PHT[0x3F]=10 → pred_takeD=1.
  - branch_cnt=7, mispred_cnt=7.
- Saturation: 3 further taken updates at 0x10 → PHT[0x3F]=11 and stays 11. Then one not-taken update (pred_takeM=1) → PHT[0x3F]=10, BHT[4]=0x3E, mispred_cnt=8, branch_cnt=11.
- Stall/flush: pred_takeD=1.
  - stallD=1 for 3 cycles with branchF=0 → pred_takeD stays 1.
  - flushD=1 and stallD=1 together → pred_takeD=0 next cycle.
- Gshare, MODE=1, HIST_W=4:
  - Updates taken at pcM=0x04, then not-taken at pcM=0x08 → GHR=0010.
  - pcF=0x08 indexes PHT[0010^0010=0] → 01 → not taken.
- Same-cycle conflict and reset mid-operation:
  - Update and fetch to the same index in one cycle → prediction uses the old counter; the new one is used the following cycle.
  - rst=0 during a training sequence → all tables and counters return to reset values.
